// File: rtl/rom_arb_pkg.sv
// Shared constants for the ROM burst arbiter: default widths, requester IDs
// and FSM state encoding.
package rom_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin selector: on a tie the requester that did not win last
// time is chosen; a lone request always wins.
module rom_arb_rr
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_id == ID_REQ1)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester burst arbiter in front of a combinational ROM. A granted burst
// walks len+1 consecutive (wrapping) addresses; read data returns one cycle later.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [2:0]        len0,
  input  logic [2:0]        len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_id,
  output logic              rd_last,
  output logic              busy
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] beat_addr;
  logic [2:0]        beats_left;
  logic              owner;
  logic              last_id;
  logic [1:0]        rr_gnt;

  rom_arb_rr u_rr (
    .req     ({req1, req0}),
    .last_id (last_id),
    .gnt     (rr_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat_addr  <= '0;
      beats_left <= '0;
      owner      <= ID_REQ0;
      last_id    <= ID_REQ1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_id      <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|rr_gnt) begin
            state      <= ST_BURST;
            gnt0       <= rr_gnt[0];
            gnt1       <= rr_gnt[1];
            owner      <= rr_gnt[1] ? ID_REQ1 : ID_REQ0;
            last_id    <= rr_gnt[1] ? ID_REQ1 : ID_REQ0;
            beat_addr  <= rr_gnt[1] ? addr1 : addr0;
            beats_left <= rr_gnt[1] ? len1 : len0;
          end
        end
        ST_BURST: begin
          // Capture the word addressed this cycle; it appears one cycle later.
          rd_data   <= rom_data;
          rd_valid  <= 1'b1;
          rd_id     <= owner;
          rd_last   <= (beats_left == 3'd0);
          beat_addr <= beat_addr + 1'b1;
          if (beats_left == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            beats_left <= beats_left - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rom_sel  = (state == ST_BURST);
  assign rom_addr = rom_sel ? beat_addr : '0;
  assign busy     = rom_sel | rd_valid;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a burst-schedule reference model predicts every output
// per cycle; directed table entries, corner sequences and random traffic.
module tb_rom_arbiter;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [2:0]    len0  = '0;
  logic [2:0]    len1  = '0;
  logic          gnt0, gnt1, rom_sel, rd_valid, rd_id, rd_last, busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, rd_data;

  always #5 clk = ~clk;

  // ROM image: word[a] = a+1, deselected ROM drives zero.
  assign rom_data = rom_sel ? ({5'd0, rom_addr} + 8'd1) : 8'd0;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
    .rd_last(rd_last), .busy(busy)
  );

  typedef struct {
    logic       r0; logic [2:0] a0; logic [2:0] l0;
    logic       r1; logic [2:0] a1; logic [2:0] l1;
    logic       win; logic [7:0] first; logic [7:0] last; int beats;
  } vec_t;
  vec_t tbl[6];

  // Expected outputs indexed by clock-edge number since reset release.
  logic          e_g0[DEPTH], e_g1[DEPTH], e_sel[DEPTH], e_v[DEPTH];
  logic          e_id[DEPTH], e_last[DEPTH], e_busy[DEPTH];
  logic [2:0]    e_addr[DEPTH];
  logic [7:0]    e_data[DEPTH];

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc, free_edge, obs_gnt_cyc, g1_cyc, id1_beats;
  logic       last_w, obs_win;
  logic [7:0] beats_q[$];
  logic       win_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, gnt0, gnt1, rom_sel, rom_addr, rd_valid, rd_id, rd_last, busy, rd_data};
  endfunction

  function automatic logic [31:0] exp_outs(int c);
    return {14'd0, e_g0[c], e_g1[c], e_sel[c], e_addr[c], e_v[c], e_id[c],
            e_last[c], e_busy[c], e_data[c]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_sel[i] = 0; e_v[i] = 0;
      e_id[i] = 0; e_last[i] = 0; e_busy[i] = 0; e_addr[i] = '0; e_data[i] = '0;
    end
    cyc = 0; free_edge = 0; last_w = 1'b1;
    beats_q.delete(); win_q.delete();
    obs_gnt_cyc = -1; g1_cyc = -1; id1_beats = 0; obs_win = 1'b0;
  endtask

  // Asserts reset now, checks outputs cleared, releases on the next negedge.
  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1 check("reset_outputs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // Model decides the upcoming edge from the current inputs, then one cycle runs.
  task automatic step(output logic g, output logic gw);
    int e;
    logic w;
    logic [2:0] a, l, ba;
    e = cyc + 1;
    g = 1'b0; gw = 1'b0;
    if (e >= free_edge && (req0 || req1)) begin
      w = (req0 && req1) ? ~last_w : req1;
      a = w ? addr1 : addr0;
      l = w ? len1 : len0;
      if (w) e_g1[e] = 1'b1; else e_g0[e] = 1'b1;
      for (int i = 0; i <= int'(l); i++) begin
        ba = a + 3'(i);
        e_sel[e+i] = 1'b1; e_addr[e+i] = ba; e_busy[e+i] = 1'b1;
        e_v[e+1+i] = 1'b1; e_data[e+1+i] = {5'd0, ba} + 8'd1;
        e_id[e+1+i] = w; e_last[e+1+i] = (i == int'(l)); e_busy[e+1+i] = 1'b1;
      end
      free_edge = e + int'(l) + 2;
      last_w = w;
      g = 1'b1; gw = w;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check($sformatf("cycle%0d_outputs", cyc), outs(), exp_outs(cyc));
    if (gnt0 || gnt1) begin
      obs_win = gnt1; obs_gnt_cyc = cyc; win_q.push_back(gnt1);
      if (gnt1 && g1_cyc < 0) g1_cyc = cyc;
    end
    if (rd_valid) begin
      beats_q.push_back(rd_data);
      if (rd_id) id1_beats++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic g, gw;
    int n;
    tbl[0] = '{1, 3'd2, 3'd3, 0, 3'd0, 3'd0, 0, 8'd3, 8'd6, 4};
    tbl[1] = '{0, 3'd0, 3'd0, 1, 3'd6, 3'd3, 1, 8'd7, 8'd2, 4};
    tbl[2] = '{1, 3'd0, 3'd7, 0, 3'd0, 3'd0, 0, 8'd1, 8'd8, 8};
    tbl[3] = '{1, 3'd5, 3'd1, 1, 3'd1, 3'd0, 0, 8'd6, 8'd7, 2};
    tbl[4] = '{0, 3'd0, 3'd0, 1, 3'd7, 3'd0, 1, 8'd8, 8'd8, 1};
    tbl[5] = '{1, 3'd4, 3'd5, 0, 3'd0, 3'd0, 0, 8'd5, 8'd2, 6};

    #2;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      req0 = tbl[t].r0; addr0 = tbl[t].a0; len0 = tbl[t].l0;
      req1 = tbl[t].r1; addr1 = tbl[t].a1; len1 = tbl[t].l1;
      n = 0;
      while (obs_gnt_cyc < 0 && n < 10) begin step(g, gw); n++; end
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 12; k++) step(g, gw);
      check($sformatf("tbl%0d_winner", t), {30'd0, obs_gnt_cyc >= 0, obs_win}, {30'd0, 1'b1, tbl[t].win});
      check($sformatf("tbl%0d_first", t), beats_q.size() > 0 ? beats_q[0] : 8'd0, tbl[t].first);
      check($sformatf("tbl%0d_last", t), beats_q.size() > 0 ? beats_q[$] : 8'd0, tbl[t].last);
      check($sformatf("tbl%0d_beats", t), beats_q.size(), tbl[t].beats);
    end

    // Both requesters held from reset with single-word bursts.
    do_reset();
    req0 = 1'b1; addr0 = 3'd0; len0 = 3'd0;
    req1 = 1'b1; addr1 = 3'd4; len1 = 3'd0;
    for (int k = 0; k < 12; k++) step(g, gw);
    req0 = 1'b0; req1 = 1'b0;
    check("alt_grant_count", win_q.size(), 6);
    for (int k = 0; k < 4; k++)
      check($sformatf("alt_grant%0d", k), win_q.size() > k ? {31'd0, win_q[k]} : 32'hFF, k % 2);

    // Reset during the third beat of an 8-beat burst.
    do_reset();
    req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
    step(g, gw);
    req0 = 1'b0;
    while (cyc < 4) step(g, gw);
    #2 do_reset();
    for (int k = 0; k < 10; k++) step(g, gw);
    check("abort_no_valid", beats_q.size(), 0);

    // Requester 1 arrives while requester 0 bursts.
    do_reset();
    req0 = 1'b1; addr0 = 3'd1; len0 = 3'd3;
    step(g, gw);
    req0 = 1'b0;
    while (cyc < 3) step(g, gw);
    req1 = 1'b1; addr1 = 3'd3; len1 = 3'd2;
    for (int k = 0; k < 12; k++) begin
      step(g, gw);
      if (g && gw) req1 = 1'b0;
    end
    check("late_gnt1_cycle", g1_cyc, 6);
    check("late_id1_beats", id1_beats, 3);

    // Random traffic against the schedule model.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(g, gw);
      if (g && $urandom_range(0, 1) == 0) begin
        if (gw) req1 = 1'b0; else req0 = 1'b0;
      end
      if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; addr0 = 3'($urandom); len0 = 3'($urandom);
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; addr1 = 3'($urandom); len1 = 3'($urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
